input_memory_node_2d: RTL and testbench
=======================================

Name: input_memory_node_2d

Overview:
Successor input memory node: an OBI read master that fetches the configuration stream, then a 2D strided data stream (rows × elements), into a parametrised FIFO feeding the IDM. It replaces the fixed latency-based request throttle with an outstanding-transaction credit scheme, so the FIFO can never overflow. Done is reported only once every requested word has been returned and consumed.

Parameters:
FIFO_DEPTH, 8, FIFO entries (power of two, ≥2)
MAX_OUTSTANDING, 4, max granted-but-not-returned reads (≤FIFO_DEPTH)
CONF_SIZE, 16'd80, configuration stream length in bytes
CONF_STRIDE, 16'd4, configuration address increment in bytes

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
clr_i  in  1  synchronous clear, same effect as reset
start_i  in  1  start configuration fetch
exec_i  in  1  execution enable
conf_needed_i  in  1  configuration fetch required
conf_addr_i  in  32  configuration base byte address
input_addr_i  in  32  data base byte address
input_size_i  in  16  bytes per row
input_stride_i  in  16  element stride within a row, in bytes
input_rows_i  in  16  row count
input_row_stride_i  in  32  row-to-row base increment, in bytes
masters_req_o  out  obi_req_t  OBI request (we=0, be=4'hF, wdata=0)
masters_resp_i  in  obi_resp_t  OBI response
conf_done_o  out  1  configuration fully delivered
done_o  out  1  data stream fully delivered
conf_en_o  out  1  configuration word valid to IDM
dout_o  out  32  data to IDM
dout_v_o  out  1  data valid
dout_r_i  in  1  data ready

Behaviour:
- Reset (rst_ni=0 at clk edge) or clr_i: state=S_IDLE, all counters 0, FIFO flushed. All outputs 0: req, conf_en_o, dout_v_o, conf_done_o, done_o. dout_o undefined.
- transaction = req & gnt. outstanding: +1 on transaction, -1 on rvalid; simultaneous events leave it unchanged.
- Credit rule: req = issuing state & (outstanding < MAX_OUTSTANDING) & (outstanding + fifo_usage < FIFO_DEPTH).
- rvalid pushes rdata into the FIFO unconditionally. The credit rule guarantees no push when full; assertion: push & full never occurs.
- Addressing: addr = base + row_base + col_off. In CONF, base=conf_addr_i and row_base=0. In data mode, base=input_addr_i. All arithmetic is 32-bit modulo; overflow wraps silently.
- On a transaction in data mode:
  - next = col_off + stride_eff, computed 17-bit.
  - If next ≥ input_size_i: col_off←0, row_base += input_row_stride_i, row_cnt++.
  - Otherwise col_off←next.
  - stride_eff = input_stride_i, or 1 if input_stride_i==0 (one element per byte; never stalls).
- FSM:
  - S_IDLE: start_i&conf_needed_i→S_CONF. Otherwise exec_i & data_valid→S_MREQ. Otherwise exec_i & !data_valid→S_DONE. data_valid = size≠0 & rows≠0.
  - S_CONF: issues at CONF_STRIDE steps. On the transaction where offset+CONF_STRIDE ≥ CONF_SIZE → S_CWAIT, offset cleared.
  - S_CWAIT: no requests. conf_done_o = (outstanding==0)&empty. When conf_done_o & exec_i: data_valid→S_MREQ, else →S_DONE.
  - S_MREQ: issues requests. On the transaction that completes row input_rows_i-1 → S_DRAIN.
  - S_DRAIN: no requests. When outstanding==0 & empty → S_DONE.
  - S_DONE: done_o=1, hold until clr_i or reset.
- FIFO pop:
  - In S_CONF/S_CWAIT: conf_en_o = !empty; pop when !empty.
  - Otherwise: dout_v_o = !empty & exec_i; pop on dout_v_o & dout_r_i.
  - dout_o is the FIFO head, first-word fall-through.
- Config inputs are sampled live and must be stable from start_i/exec_i until done_o.
- Reset or clr_i mid-transaction drops in-flight responses. The bench must not return rvalid after clear.

Test Plan:
- Conf fetch, CONF_SIZE=16, conf_addr=0x1000, gnt always, rvalid 1 cycle later → addrs 0x1000,04,08,0C; 4 conf_en_o pulses; conf_done_o after last pop; no 5th request.
- 2D data: input_addr=0x2000, size=8, stride=4, rows=3, row_stride=0x100 → addrs 0x2000,2004,2100,2104,2200,2204; 6 dout words in order; done_o only after 6th pop.
- Backpressure: dout_r_i=0, FIFO_DEPTH=8, immediate rvalid → at most 8 grants, then req=0; releasing dout_r_i resumes issue; no word lost or duplicated.
- Outstanding limit: rvalid delayed 10 cycles, MAX_OUTSTANDING=4 → exactly 4 grants, then req=0 until the first rvalid.
- Degenerate: rows=0 or size=0 with exec_i → S_DONE next cycle, zero requests, done_o=1. stride=0, size=3 → 3 reads per row at byte offsets 0,1,2.
- clr_i asserted in S_MREQ with 2 outstanding → next cycle req=0, FIFO empty, done_o=0, state idle; a fresh exec_i restarts from offset 0.

Source files
------------

// File: rtl/input_memory_node_2d.sv
// OBI read master that fetches a config stream, then a 2D strided data stream, into a first-word-fall-through FIFO.
// A read is issued only when a FIFO slot is reserved for it, so a returned word can always be stored.

package input_memory_node_2d_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module input_memory_node_2d
    import input_memory_node_2d_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [15:0] CONF_SIZE       = 16'd80,
    parameter logic [15:0] CONF_STRIDE     = 16'd4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        start_i,
    input  logic        exec_i,
    input  logic        conf_needed_i,
    input  logic [31:0] conf_addr_i,
    input  logic [31:0] input_addr_i,
    input  logic [15:0] input_size_i,
    input  logic [15:0] input_stride_i,
    input  logic [15:0] input_rows_i,
    input  logic [31:0] input_row_stride_i,
    output obi_req_t    masters_req_o,
    input  obi_resp_t   masters_resp_i,
    output logic        conf_done_o,
    output logic        done_o,
    output logic        conf_en_o,
    output logic [31:0] dout_o,
    output logic        dout_v_o,
    input  logic        dout_r_i
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 2;
    localparam logic [PTR_W:0] ONE = (PTR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONF,
        S_CWAIT,
        S_MREQ,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [PTR_W:0] outstanding_q, outstanding_d;
    logic [15:0]    conf_off_q, conf_off_d;
    logic [15:0]    col_off_q, col_off_d;
    logic [31:0]    row_base_q, row_base_d;
    logic [15:0]    row_cnt_q, row_cnt_d;
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]    fifo_mem_q [FIFO_DEPTH];

    logic [PTR_W:0] usage;
    logic           empty, full, push, pop;
    logic           issuing, credit_ok, req, trans;
    logic           conf_mode, drained, data_valid;
    logic [15:0]    stride_eff;
    logic [16:0]    col_next, conf_next;
    logic           row_wrap, last_row, conf_last;

    always_comb begin
        usage      = wr_ptr_q - rd_ptr_q;
        empty      = (usage == '0);
        full       = (usage == (PTR_W+1)'(FIFO_DEPTH));
        push       = masters_resp_i.rvalid;
        issuing    = (state_q == S_CONF) || (state_q == S_MREQ);
        // Every in-flight read owns a FIFO slot, so a push can never hit a full FIFO.
        credit_ok  = (outstanding_q < (PTR_W+1)'(MAX_OUTSTANDING)) &&
                     (({1'b0, outstanding_q} + {1'b0, usage}) < CNT_W'(FIFO_DEPTH));
        req        = issuing && credit_ok;
        trans      = req && masters_resp_i.gnt;
        conf_mode  = (state_q == S_CONF) || (state_q == S_CWAIT);
        drained    = (outstanding_q == '0) && empty;
        data_valid = (input_size_i != 16'd0) && (input_rows_i != 16'd0);
        stride_eff = (input_stride_i == 16'd0) ? 16'd1 : input_stride_i;
        col_next   = {1'b0, col_off_q} + {1'b0, stride_eff};
        row_wrap   = (col_next >= {1'b0, input_size_i});
        last_row   = (row_cnt_q == (input_rows_i - 16'd1));
        conf_next  = {1'b0, conf_off_q} + {1'b0, CONF_STRIDE};
        conf_last  = (conf_next >= {1'b0, CONF_SIZE});

        conf_en_o   = conf_mode && !empty;
        dout_v_o    = !conf_mode && !empty && exec_i;
        pop         = conf_mode ? !empty : (dout_v_o && dout_r_i);
        dout_o      = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
        conf_done_o = (state_q == S_CWAIT) && drained;
        done_o      = (state_q == S_DONE);

        masters_req_o       = '0;
        masters_req_o.req   = req;
        masters_req_o.be    = 4'hF;
        masters_req_o.addr  = (state_q == S_CONF) ? (conf_addr_i + {16'd0, conf_off_q})
                                                  : (input_addr_i + row_base_q + {16'd0, col_off_q});
    end

    always_comb begin
        state_d       = state_q;
        conf_off_d    = conf_off_q;
        col_off_d     = col_off_q;
        row_base_d    = row_base_q;
        row_cnt_d     = row_cnt_q;
        outstanding_d = outstanding_q;
        wr_ptr_d      = wr_ptr_q + (push ? ONE : '0);
        rd_ptr_d      = rd_ptr_q + (pop ? ONE : '0);

        if (trans && !push) begin
            outstanding_d = outstanding_q + ONE;
        end else if (!trans && push) begin
            outstanding_d = outstanding_q - ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i && conf_needed_i) begin
                    state_d = S_CONF;
                end else if (exec_i && data_valid) begin
                    state_d = S_MREQ;
                end else if (exec_i) begin
                    state_d = S_DONE;
                end
            end
            S_CONF: begin
                if (trans) begin
                    if (conf_last) begin
                        conf_off_d = 16'd0;
                        state_d    = S_CWAIT;
                    end else begin
                        conf_off_d = conf_next[15:0];
                    end
                end
            end
            S_CWAIT: begin
                if (conf_done_o && exec_i) begin
                    state_d = data_valid ? S_MREQ : S_DONE;
                end
            end
            S_MREQ: begin
                if (trans) begin
                    if (row_wrap) begin
                        col_off_d  = 16'd0;
                        row_base_d = row_base_q + input_row_stride_i;
                        row_cnt_d  = row_cnt_q + 16'd1;
                        if (last_row) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        col_off_d = col_next[15:0];
                    end
                end
            end
            S_DRAIN: begin
                if (drained) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            state_q       <= S_IDLE;
            outstanding_q <= '0;
            conf_off_q    <= '0;
            col_off_q     <= '0;
            row_base_q    <= '0;
            row_cnt_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            conf_off_q    <= conf_off_d;
            col_off_q     <= col_off_d;
            row_base_q    <= row_base_d;
            row_cnt_q     <= row_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= masters_resp_i.rdata;
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni && !clr_i) begin
            assert (!(push && full));
        end
    end

endmodule

// File: tb/tb_input_memory_node_2d.sv
// Bench for input_memory_node_2d: OBI slave with random grant/latency, random sink, queue-based stream model.
module tb_input_memory_node_2d;
    import input_memory_node_2d_pkg::*;

    localparam int CS  = 16;
    localparam int CST = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni, clr_i, start_i, exec_i, conf_needed_i;
    logic [31:0] conf_addr_i, input_addr_i, input_row_stride_i;
    logic [15:0] input_size_i, input_stride_i, input_rows_i;
    obi_req_t    masters_req_o;
    obi_resp_t   masters_resp_i;
    logic        conf_done_o, done_o, conf_en_o, dout_v_o, dout_r_i;
    logic [31:0] dout_o;

    always #5 clk_i = ~clk_i;

    input_memory_node_2d #(
        .FIFO_DEPTH(8), .MAX_OUTSTANDING(4), .CONF_SIZE(16'(CS)), .CONF_STRIDE(16'(CST))
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .start_i(start_i), .exec_i(exec_i),
        .conf_needed_i(conf_needed_i), .conf_addr_i(conf_addr_i), .input_addr_i(input_addr_i),
        .input_size_i(input_size_i), .input_stride_i(input_stride_i), .input_rows_i(input_rows_i),
        .input_row_stride_i(input_row_stride_i), .masters_req_o(masters_req_o),
        .masters_resp_i(masters_resp_i), .conf_done_o(conf_done_o), .done_o(done_o),
        .conf_en_o(conf_en_o), .dout_o(dout_o), .dout_v_o(dout_v_o), .dout_r_i(dout_r_i)
    );

    int n_vec = 0;
    int n_err = 0;

    bit          gnt_rand = 1'b0;
    int          lat_min = 1, lat_max = 1, rdy_mode = 1;
    logic [31:0] grant_addr[$];
    logic [31:0] pop_dat[$];
    logic [31:0] conf_dat[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          grant_bad = 0;
    int          rv_cnt = 0;
    int          cyc = 0;

    logic [31:0] exp_addr[$];
    int          exp_nconf;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Slave and sink act on the falling edge, so the DUT sees them settled at the next rising edge.
    initial begin
        masters_resp_i = '0;
        dout_r_i = 1'b0;
        forever begin
            @(negedge clk_i);
            cyc++;
            masters_resp_i = '0;
            if (!rst_ni || clr_i) begin
                pend_addr.delete();
                pend_due.delete();
                dout_r_i = 1'b0;
            end else begin
                if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                    masters_resp_i.rvalid = 1'b1;
                    masters_resp_i.rdata  = mem_word(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                    rv_cnt++;
                end
                masters_resp_i.gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                if (masters_req_o.req && masters_resp_i.gnt) begin
                    grant_addr.push_back(masters_req_o.addr);
                    if (masters_req_o.we || masters_req_o.be != 4'hF || masters_req_o.wdata != 32'd0)
                        grant_bad++;
                    pend_addr.push_back(masters_req_o.addr);
                    pend_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
                end
                dout_r_i = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
                if (dout_v_o && dout_r_i) pop_dat.push_back(dout_o);
                if (conf_en_o) conf_dat.push_back(dout_o);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic build_exp(input bit with_conf, input logic [31:0] cbase, input logic [31:0] base,
                             input int size, input int stride, input int rows, input logic [31:0] rs);
        int se;
        se = (stride == 0) ? 1 : stride;
        exp_addr.delete();
        exp_nconf = 0;
        if (with_conf) begin
            int o = 0;
            do begin
                exp_addr.push_back(cbase + 32'(o));
                o += CST;
                exp_nconf++;
            end while (o < CS);
        end
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < size; c += se)
                exp_addr.push_back(base + 32'(r) * rs + 32'(c));
    endtask

    task automatic clear_bench(input bit grnd, input int lmin, input int lmax, input int rmode);
        @(posedge clk_i); #1;
        exec_i = 1'b0; start_i = 1'b0; conf_needed_i = 1'b0; clr_i = 1'b1;
        gnt_rand = grnd; lat_min = lmin; lat_max = lmax; rdy_mode = rmode;
        @(posedge clk_i); #1;
        clr_i = 1'b0;
        grant_addr.delete(); pop_dat.delete(); conf_dat.delete();
        grant_bad = 0; rv_cnt = 0;
    endtask

    task automatic apply_cfg(input logic [31:0] base, input int size, input int stride,
                             input int rows, input logic [31:0] rs);
        input_addr_i = base; input_size_i = 16'(size); input_stride_i = 16'(stride);
        input_rows_i = 16'(rows); input_row_stride_i = rs;
    endtask

    task automatic wait_done(input int budget, output bit seen, output int pops_at_done);
        int t = 0;
        while (!done_o && t < budget) begin
            @(posedge clk_i); #1;
            t++;
        end
        seen = done_o;
        pops_at_done = pop_dat.size();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; clr_i = 1'b0; start_i = 1'b0; exec_i = 1'b0; conf_needed_i = 1'b0;
        conf_addr_i = '0;
        apply_cfg(32'd0, 0, 0, 0, 32'd0);
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        n_vec++; if (masters_req_o.req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", masters_req_o.req); end
        n_vec++; if (conf_en_o !== 1'b0) begin n_err++; $display("FAIL reset_conf_en: got %b want 0", conf_en_o); end
        n_vec++; if (conf_done_o !== 1'b0) begin n_err++; $display("FAIL reset_conf_done: got %b want 0", conf_done_o); end
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_o); end
        exec_i = 1'b1;
        #1;
        n_vec++; if (dout_v_o !== 1'b0) begin n_err++; $display("FAIL reset_dout_v: got %b want 0", dout_v_o); end
        exec_i = 1'b0;
    endtask

    task automatic test_conf();
        int t = 0;
        int pops;
        bit seen;
        clear_bench(1'b0, 1, 1, 1);
        conf_addr_i = 32'h1000;
        apply_cfg(32'h3000, 4, 4, 1, 32'h0);
        build_exp(1'b1, 32'h1000, 32'h3000, 4, 4, 1, 32'h0);
        start_i = 1'b1; conf_needed_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        while (!conf_done_o && t < 200) begin @(posedge clk_i); #1; t++; end
        n_vec++; if (conf_done_o !== 1'b1) begin n_err++; $display("FAIL conf_done_seen: got %b want 1", conf_done_o); end
        n_vec++; if (conf_dat.size() != 4) begin n_err++; $display("FAIL conf_pops_at_done: got %0d want 4", conf_dat.size()); end
        repeat (10) @(posedge clk_i); #1;
        n_vec++; if (grant_addr.size() != 4) begin n_err++; $display("FAIL conf_grants: got %0d want 4", grant_addr.size()); end
        n_vec++; if (conf_done_o !== 1'b1 || done_o !== 1'b0) begin n_err++; $display("FAIL conf_hold: got %b%b want 10", conf_done_o, done_o); end
        exec_i = 1'b1;
        wait_done(200, seen, pops);
        n_vec++; if (!seen || pops != 1) begin n_err++; $display("FAIL conf_then_data: got done=%b pops=%0d want done=1 pops=1", seen, pops); end
        n_vec++; if (grant_addr.size() != exp_addr.size()) begin n_err++; $display("FAIL conf_total_grants: got %0d want %0d", grant_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < grant_addr.size(); i++) begin
            n_vec++; if (grant_addr[i] !== exp_addr[i]) begin n_err++; $display("FAIL conf_addr[%0d]: got %h want %h", i, grant_addr[i], exp_addr[i]); end
        end
        for (int i = 0; i < conf_dat.size() && i < exp_nconf; i++) begin
            n_vec++; if (conf_dat[i] !== mem_word(exp_addr[i])) begin n_err++; $display("FAIL conf_word[%0d]: got %h want %h", i, conf_dat[i], mem_word(exp_addr[i])); end
        end
        n_vec++; if (pop_dat.size() != 1 || pop_dat[0] !== mem_word(32'h3000)) begin n_err++; $display("FAIL conf_data_word: got n=%0d want n=1 word %h", pop_dat.size(), mem_word(32'h3000)); end
        n_vec++; if (grant_bad != 0) begin n_err++; $display("FAIL conf_req_fields: got %0d bad want 0", grant_bad); end
    endtask

    task automatic test_2d();
        int pops;
        bit seen;
        clear_bench(1'b0, 1, 1, 1);
        apply_cfg(32'h2000, 8, 4, 3, 32'h100);
        build_exp(1'b0, 32'h0, 32'h2000, 8, 4, 3, 32'h100);
        exec_i = 1'b1;
        wait_done(300, seen, pops);
        n_vec++; if (!seen || pops != 6) begin n_err++; $display("FAIL 2d_done_after_pops: got done=%b pops=%0d want done=1 pops=6", seen, pops); end
        n_vec++; if (grant_addr.size() != 6) begin n_err++; $display("FAIL 2d_grants: got %0d want 6", grant_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < grant_addr.size(); i++) begin
            n_vec++; if (grant_addr[i] !== exp_addr[i]) begin n_err++; $display("FAIL 2d_addr[%0d]: got %h want %h", i, grant_addr[i], exp_addr[i]); end
        end
        for (int i = 0; i < exp_addr.size() && i < pop_dat.size(); i++) begin
            n_vec++; if (pop_dat[i] !== mem_word(exp_addr[i])) begin n_err++; $display("FAIL 2d_word[%0d]: got %h want %h", i, pop_dat[i], mem_word(exp_addr[i])); end
        end
        repeat (5) @(posedge clk_i); #1;
        n_vec++; if (done_o !== 1'b1 || masters_req_o.req !== 1'b0) begin n_err++; $display("FAIL 2d_done_hold: got done=%b req=%b want 1 0", done_o, masters_req_o.req); end
    endtask

    task automatic test_backpressure();
        int pops;
        bit seen;
        clear_bench(1'b0, 1, 1, 0);
        apply_cfg(32'h4000, 64, 4, 1, 32'h0);
        build_exp(1'b0, 32'h0, 32'h4000, 64, 4, 1, 32'h0);
        exec_i = 1'b1;
        repeat (30) @(posedge clk_i); #1;
        n_vec++; if (grant_addr.size() != 8) begin n_err++; $display("FAIL bp_grants: got %0d want 8", grant_addr.size()); end
        n_vec++; if (masters_req_o.req !== 1'b0 || dout_v_o !== 1'b1) begin n_err++; $display("FAIL bp_stall: got req=%b v=%b want 0 1", masters_req_o.req, dout_v_o); end
        rdy_mode = 1;
        wait_done(500, seen, pops);
        n_vec++; if (!seen || pops != exp_addr.size()) begin n_err++; $display("FAIL bp_done: got done=%b pops=%0d want 1 %0d", seen, pops, exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < pop_dat.size(); i++) begin
            n_vec++; if (pop_dat[i] !== mem_word(exp_addr[i])) begin n_err++; $display("FAIL bp_word[%0d]: got %h want %h", i, pop_dat[i], mem_word(exp_addr[i])); end
        end
    endtask

    task automatic test_outstanding();
        int t = 0;
        int pops;
        bit seen;
        clear_bench(1'b0, 10, 10, 1);
        apply_cfg(32'h5000, 40, 4, 2, 32'h40);
        build_exp(1'b0, 32'h0, 32'h5000, 40, 4, 2, 32'h40);
        exec_i = 1'b1;
        while (grant_addr.size() < 4 && t < 50) begin @(posedge clk_i); #1; t++; end
        repeat (3) @(posedge clk_i); #1;
        n_vec++; if (grant_addr.size() != 4 || rv_cnt != 0) begin n_err++; $display("FAIL os_limit: got grants=%0d rvalids=%0d want 4 0", grant_addr.size(), rv_cnt); end
        n_vec++; if (masters_req_o.req !== 1'b0) begin n_err++; $display("FAIL os_req_low: got %b want 0", masters_req_o.req); end
        wait_done(1500, seen, pops);
        n_vec++; if (!seen || pops != exp_addr.size()) begin n_err++; $display("FAIL os_done: got done=%b pops=%0d want 1 %0d", seen, pops, exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < pop_dat.size(); i++) begin
            n_vec++; if (pop_dat[i] !== mem_word(exp_addr[i])) begin n_err++; $display("FAIL os_word[%0d]: got %h want %h", i, pop_dat[i], mem_word(exp_addr[i])); end
        end
    endtask

    task automatic test_degenerate();
        int pops;
        bit seen;
        for (int k = 0; k < 2; k++) begin
            clear_bench(1'b0, 1, 1, 1);
            apply_cfg(32'h6000, (k == 0) ? 8 : 0, 4, (k == 0) ? 0 : 3, 32'h10);
            exec_i = 1'b1;
            @(posedge clk_i); #1;
            n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL degen%0d_done: got %b want 1", k, done_o); end
            repeat (3) @(posedge clk_i); #1;
            n_vec++; if (grant_addr.size() != 0) begin n_err++; $display("FAIL degen%0d_reqs: got %0d want 0", k, grant_addr.size()); end
        end
        clear_bench(1'b0, 1, 1, 1);
        apply_cfg(32'h6001, 3, 0, 2, 32'h10);
        build_exp(1'b0, 32'h0, 32'h6001, 3, 0, 2, 32'h10);
        exec_i = 1'b1;
        wait_done(300, seen, pops);
        n_vec++; if (!seen || grant_addr.size() != 6) begin n_err++; $display("FAIL stride0_count: got done=%b grants=%0d want 1 6", seen, grant_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < grant_addr.size(); i++) begin
            n_vec++; if (grant_addr[i] !== exp_addr[i]) begin n_err++; $display("FAIL stride0_addr[%0d]: got %h want %h", i, grant_addr[i], exp_addr[i]); end
        end
    endtask

    task automatic test_clear();
        int t = 0;
        int pops;
        bit seen;
        clear_bench(1'b0, 10, 10, 1);
        apply_cfg(32'h7000, 32, 4, 2, 32'h80);
        build_exp(1'b0, 32'h0, 32'h7000, 32, 4, 2, 32'h80);
        exec_i = 1'b1;
        while (grant_addr.size() < 2 && t < 50) begin @(posedge clk_i); #1; t++; end
        clr_i = 1'b1;
        @(posedge clk_i); #1;
        clr_i = 1'b0;
        lat_min = 1; lat_max = 3;
        n_vec++; if (masters_req_o.req !== 1'b0) begin n_err++; $display("FAIL clr_req: got %b want 0", masters_req_o.req); end
        n_vec++; if (dout_v_o !== 1'b0 || done_o !== 1'b0) begin n_err++; $display("FAIL clr_empty_done: got v=%b done=%b want 0 0", dout_v_o, done_o); end
        grant_addr.delete(); pop_dat.delete();
        wait_done(800, seen, pops);
        n_vec++; if (!seen || pops != exp_addr.size()) begin n_err++; $display("FAIL clr_restart_done: got done=%b pops=%0d want 1 %0d", seen, pops, exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < grant_addr.size(); i++) begin
            n_vec++; if (grant_addr[i] !== exp_addr[i]) begin n_err++; $display("FAIL clr_addr[%0d]: got %h want %h", i, grant_addr[i], exp_addr[i]); end
        end
        for (int i = 0; i < exp_addr.size() && i < pop_dat.size(); i++) begin
            n_vec++; if (pop_dat[i] !== mem_word(exp_addr[i])) begin n_err++; $display("FAIL clr_word[%0d]: got %h want %h", i, pop_dat[i], mem_word(exp_addr[i])); end
        end
    endtask

    task automatic test_random();
        int pops;
        bit seen;
        for (int it = 0; it < 6; it++) begin
            logic [31:0] base, rs, cbase;
            int size, stride, rows;
            bit wc;
            base = $urandom; rs = $urandom; cbase = $urandom & 32'hFFFF_FFFC;
            size = $urandom_range(1, 24); stride = $urandom_range(0, 7); rows = $urandom_range(1, 4);
            wc = it[0];
            clear_bench(1'b1, 1, 4, 2);
            conf_addr_i = cbase;
            apply_cfg(base, size, stride, rows, rs);
            build_exp(wc, cbase, base, size, stride, rows, rs);
            start_i = wc; conf_needed_i = wc; exec_i = 1'b1;
            @(posedge clk_i); #1;
            start_i = 1'b0;
            wait_done(3000, seen, pops);
            n_vec++; if (!seen || pops != exp_addr.size() - exp_nconf) begin n_err++; $display("FAIL rnd%0d_done: got done=%b pops=%0d want 1 %0d", it, seen, pops, exp_addr.size() - exp_nconf); end
            n_vec++; if (grant_addr.size() != exp_addr.size() || conf_dat.size() != exp_nconf) begin n_err++; $display("FAIL rnd%0d_counts: got g=%0d c=%0d want %0d %0d", it, grant_addr.size(), conf_dat.size(), exp_addr.size(), exp_nconf); end
            for (int i = 0; i < exp_addr.size() && i < grant_addr.size(); i++) begin
                n_vec++; if (grant_addr[i] !== exp_addr[i]) begin n_err++; $display("FAIL rnd%0d_addr[%0d]: got %h want %h", it, i, grant_addr[i], exp_addr[i]); end
            end
            for (int i = 0; i < conf_dat.size() && i < exp_nconf; i++) begin
                n_vec++; if (conf_dat[i] !== mem_word(exp_addr[i])) begin n_err++; $display("FAIL rnd%0d_conf[%0d]: got %h want %h", it, i, conf_dat[i], mem_word(exp_addr[i])); end
            end
            for (int i = 0; i < pop_dat.size() && i + exp_nconf < exp_addr.size(); i++) begin
                n_vec++; if (pop_dat[i] !== mem_word(exp_addr[i + exp_nconf])) begin n_err++; $display("FAIL rnd%0d_word[%0d]: got %h want %h", it, i, pop_dat[i], mem_word(exp_addr[i + exp_nconf])); end
            end
            n_vec++; if (grant_bad != 0) begin n_err++; $display("FAIL rnd%0d_req_fields: got %0d bad want 0", it, grant_bad); end
        end
    endtask

    initial begin
        test_reset();
        test_conf();
        test_2d();
        test_backpressure();
        test_outstanding();
        test_degenerate();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
